// File: rtl/radar_pkg.sv
// Shared types and constants for the radar pulse sequencer slice.
package radar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pulse_seq_state_t;

    localparam int MIN_PRI = 2;
    localparam int BURST_W = 16;

endpackage

// File: rtl/pri_stagger_table.sv
// PRI stagger table: register array with one write port and an indexed read
// of the stored (pre-edge) contents, giving read-before-write on a shared edge.
module pri_stagger_table #(
    parameter int STG_DEPTH   = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_PRI = 1000,
    parameter int STG_AW      = $clog2(STG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [STG_AW-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [STG_AW-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data
);

    logic [CNT_W-1:0] mem [STG_DEPTH];

    // NOTE: this array is small and flop-based, so every entry gets a reset
    // value; a RAM macro could not be reset like this and would need an init FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STG_DEPTH; i++) begin
                mem[i] <= CNT_W'(DEFAULT_PRI);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/radar_pulse_sequencer.sv
// Staggered-PRI radar TX gate sequencer with continuous and triggered-burst
// modes; every output is a flop.
module radar_pulse_sequencer
    import radar_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int STG_DEPTH   = 4,
    parameter int STG_AW      = $clog2(STG_DEPTH),
    parameter int DEFAULT_PRI = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               burst_mode,
    input  logic               trigger,
    input  logic [15:0]        burst_count,
    input  logic [CNT_W-1:0]   pulse_width,
    input  logic [STG_AW:0]    stagger_len,
    input  logic               tbl_wr_en,
    input  logic [STG_AW-1:0]  tbl_wr_addr,
    input  logic [CNT_W-1:0]   tbl_wr_data,
    output logic               tx_pulse,
    output logic               pulse_start,
    output logic [STG_AW-1:0]  pri_index,
    output logic               busy,
    output logic               burst_done
);

    pulse_seq_state_t state, next_state;

    logic [CNT_W-1:0]   pri_cnt;
    logic [CNT_W-1:0]   pri_len_q;
    logic [CNT_W-1:0]   pw_q;
    logic [BURST_W-1:0] pulse_cnt;
    logic [BURST_W-1:0] burst_cnt_q;
    logic               burst_mode_q;

    logic               last_cycle;
    logic               burst_last;
    logic               start_run;
    logic               wrap_pri;
    logic               end_burst;
    logic               load_pri;
    logic [STG_AW:0]    stg_len_eff;
    logic [STG_AW-1:0]  next_idx;
    logic [CNT_W-1:0]   rd_data;
    logic [CNT_W-1:0]   new_pri_len;
    logic [CNT_W-1:0]   new_pw;

    logic               tx_next;
    logic               start_next;
    logic               busy_next;
    logic               done_next;

    pri_stagger_table #(
        .STG_DEPTH  (STG_DEPTH),
        .CNT_W      (CNT_W),
        .DEFAULT_PRI(DEFAULT_PRI),
        .STG_AW     (STG_AW)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (tbl_wr_en),
        .wr_addr(tbl_wr_addr),
        .wr_data(tbl_wr_data),
        .rd_addr(next_idx),
        .rd_data(rd_data)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // PRI bookkeeping shared by next-state and output logic.
    always_comb begin
        if (stagger_len == '0) begin
            stg_len_eff = (STG_AW+1)'(1);
        end else if (stagger_len > (STG_AW+1)'(STG_DEPTH)) begin
            stg_len_eff = (STG_AW+1)'(STG_DEPTH);
        end else begin
            stg_len_eff = stagger_len;
        end
    end

    assign last_cycle = (pri_cnt == pri_len_q - CNT_W'(1));
    assign burst_last = burst_mode_q &&
                        (({1'b0, pulse_cnt} + (BURST_W+1)'(1)) >= {1'b0, burst_cnt_q});

    // Next-state logic.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enable && (!burst_mode || trigger)) next_state = RUN;
            RUN: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (last_cycle && burst_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign start_run = (state == IDLE) && (next_state == RUN);
    assign wrap_pri  = (state == RUN) && enable && last_cycle && !burst_last;
    assign end_burst = (state == RUN) && enable && last_cycle && burst_last;
    assign load_pri  = start_run || wrap_pri;

    // Index wraps modulo the stagger length sampled as the new PRI begins.
    assign next_idx = start_run ? '0 :
                      STG_AW'(({1'b0, pri_index} + (STG_AW+1)'(1)) % stg_len_eff);

    assign new_pri_len = (rd_data < CNT_W'(MIN_PRI)) ? CNT_W'(MIN_PRI) : rd_data;
    assign new_pw      = (pulse_width < new_pri_len) ? pulse_width
                                                     : new_pri_len - CNT_W'(1);

    // Output logic: next values of the registered outputs.
    always_comb begin
        tx_next    = 1'b0;
        start_next = load_pri;
        busy_next  = (next_state == RUN);
        done_next  = end_burst;
        if (load_pri) begin
            tx_next = (new_pw != '0);
        end else if ((state == RUN) && (next_state == RUN)) begin
            tx_next = ((pri_cnt + CNT_W'(1)) < pw_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pulse     <= 1'b0;
            pulse_start  <= 1'b0;
            busy         <= 1'b0;
            burst_done   <= 1'b0;
            pri_index    <= '0;
            pri_cnt      <= '0;
            pri_len_q    <= '0;
            pw_q         <= '0;
            pulse_cnt    <= '0;
            burst_cnt_q  <= '0;
            burst_mode_q <= 1'b0;
        end else begin
            tx_pulse    <= tx_next;
            pulse_start <= start_next;
            busy        <= busy_next;
            burst_done  <= done_next;

            if (start_run) begin
                burst_mode_q <= burst_mode;
                burst_cnt_q  <= (burst_count == '0) ? BURST_W'(1) : burst_count;
                pulse_cnt    <= '0;
            end else if (wrap_pri) begin
                pulse_cnt <= pulse_cnt + BURST_W'(1);
            end

            if (load_pri) begin
                pri_cnt   <= '0;
                pri_len_q <= new_pri_len;
                pw_q      <= new_pw;
                pri_index <= next_idx;
            end else if (state == RUN) begin
                pri_cnt <= pri_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_radar_pulse_sequencer.sv
// Bench for radar_pulse_sequencer: directed scenarios plus random stimulus,
// compared each cycle against a PRI-trace reference model.
module tb_radar_pulse_sequencer;

    localparam int CNT_W     = 32;
    localparam int STG_DEPTH = 4;
    localparam int STG_AW    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               burst_mode;
    logic               trigger;
    logic [15:0]        burst_count;
    logic [CNT_W-1:0]   pulse_width;
    logic [STG_AW:0]    stagger_len;
    logic               tbl_wr_en;
    logic [STG_AW-1:0]  tbl_wr_addr;
    logic [CNT_W-1:0]   tbl_wr_data;
    logic               tx_pulse;
    logic               pulse_start;
    logic [STG_AW-1:0]  pri_index;
    logic               busy;
    logic               burst_done;

    radar_pulse_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .burst_mode (burst_mode),
        .trigger    (trigger),
        .burst_count(burst_count),
        .pulse_width(pulse_width),
        .stagger_len(stagger_len),
        .tbl_wr_en  (tbl_wr_en),
        .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data),
        .tx_pulse   (tx_pulse),
        .pulse_start(pulse_start),
        .pri_index  (pri_index),
        .busy       (busy),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              tx;
        logic              start;
        logic              busy;
        logic              done;
        logic [STG_AW-1:0] idx;
    } exp_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: each PRI is expanded into its full output trace.
    logic [CNT_W-1:0] m_tbl [STG_DEPTH];
    exp_t             m_q [$];
    exp_t             m_cur;
    bit               m_run;
    bit               m_bm;
    bit               m_chk_idx;
    int               m_bc;
    int               m_k;
    int               m_idx;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int len_eff(input logic [STG_AW:0] s);
        if (s == 0) return 1;
        if (s > STG_DEPTH) return STG_DEPTH;
        return int'(s);
    endfunction

    task automatic gen_pri(input int idx);
        longint unsigned len, pw;
        exp_t e;
        len = (m_tbl[idx] < 2) ? 2 : longint'(m_tbl[idx]);
        pw  = (longint'(pulse_width) < len - 1) ? longint'(pulse_width) : len - 1;
        for (longint unsigned c = 0; c < len; c++) begin
            e.tx    = (c < pw);
            e.start = (c == 0);
            e.busy  = 1'b1;
            e.done  = 1'b0;
            e.idx   = STG_AW'(idx);
            m_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < STG_DEPTH; i++) m_tbl[i] = 32'd1000;
        m_q.delete();
        m_run     = 1'b0;
        m_cur     = '0;
        m_chk_idx = 1'b1;
    endtask

    // Evaluated at each rising edge with the inputs the DUT samples there.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_chk_idx = 1'b0;
        if (m_run) begin
            if (!enable) begin
                m_run = 1'b0;
                m_q.delete();
                m_cur = '0;
            end else begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_k++;
                    if (m_bm && m_k >= m_bc) begin
                        m_run = 1'b0;
                        m_cur = '0;
                        m_cur.done = 1'b1;
                    end else begin
                        m_idx = (m_idx + 1) % len_eff(stagger_len);
                        gen_pri(m_idx);
                        m_cur = m_q[0];
                    end
                end else begin
                    m_cur = m_q[0];
                end
            end
        end else if (enable && (!burst_mode || trigger)) begin
            m_run = 1'b1;
            m_bm  = burst_mode;
            m_bc  = (burst_count == 0) ? 1 : int'(burst_count);
            m_k   = 0;
            m_idx = 0;
            gen_pri(0);
            m_cur = m_q[0];
        end else begin
            m_cur = '0;
        end
        if (tbl_wr_en) m_tbl[tbl_wr_addr] = tbl_wr_data;
    endtask

    task automatic compare(input string tag);
        logic [STG_AW-1:0] obs_idx;
        obs_idx = (m_cur.busy || m_chk_idx) ? pri_index : '0;
        check($sformatf("%s@%0d", tag, cyc),
              {2'b00, tx_pulse, pulse_start, busy, burst_done, obs_idx},
              {2'b00, m_cur});
    endtask

    string phase = "reset";

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare(phase);
    endtask

    task automatic wr(input int addr, input int data);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = STG_AW'(addr);
        tbl_wr_data = CNT_W'(data);
        cycle();
        tbl_wr_en   = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        burst_mode  = 1'b0;
        trigger     = 1'b0;
        burst_count = 16'd0;
        pulse_width = '0;
        stagger_len = 3'd1;
        tbl_wr_en   = 1'b0;
        tbl_wr_addr = '0;
        tbl_wr_data = '0;
        model_reset();

        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        phase = "continuous";
        wr(0, 10);
        pulse_width = 3;
        enable = 1'b1;
        repeat (45) cycle();
        enable = 1'b0;
        cycle();

        phase = "stagger";
        wr(0, 8); wr(1, 12); wr(2, 16); wr(3, 20);
        stagger_len = 3'd4;
        pulse_width = 2;
        enable = 1'b1;
        repeat (120) cycle();
        enable = 1'b0;
        cycle();

        phase = "burst";
        stagger_len = 3'd1;
        wr(0, 6);
        burst_mode  = 1'b1;
        burst_count = 16'd3;
        enable  = 1'b1;
        trigger = 1'b1;
        cycle();
        trigger = 1'b0;
        repeat (8) cycle();
        trigger = 1'b1;
        cycle();
        trigger = 1'b0;
        repeat (15) cycle();

        phase = "burst_chain";
        trigger = 1'b1;
        repeat (45) cycle();
        trigger = 1'b0;
        repeat (20) cycle();

        phase = "clamp";
        wr(0, 1);
        pulse_width = 50;
        burst_count = 16'd0;
        trigger = 1'b1;
        cycle();
        trigger = 1'b0;
        repeat (6) cycle();
        burst_mode = 1'b0;
        repeat (10) cycle();
        enable = 1'b0;
        cycle();

        phase = "abort";
        wr(0, 10);
        pulse_width = 5;
        enable = 1'b1;
        repeat (13) cycle();
        enable = 1'b0;
        repeat (3) cycle();
        burst_mode  = 1'b1;
        burst_count = 16'd3;
        enable  = 1'b1;
        trigger = 1'b1;
        cycle();
        trigger = 1'b0;
        repeat (14) cycle();
        enable = 1'b0;
        repeat (3) cycle();

        phase = "tbl_write";
        burst_mode = 1'b0;
        wr(0, 8); wr(1, 12);
        stagger_len = 3'd2;
        pulse_width = 2;
        enable = 1'b1;
        repeat (11) cycle();
        wr(1, 30);
        repeat (80) cycle();
        enable = 1'b0;
        cycle();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            enable      = ($urandom_range(0, 19) != 0);
            burst_mode  = $urandom_range(0, 1);
            trigger     = ($urandom_range(0, 4) == 0);
            burst_count = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) pulse_width = CNT_W'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) stagger_len = 3'($urandom_range(0, 7));
            tbl_wr_en   = ($urandom_range(0, 3) == 0);
            tbl_wr_addr = STG_AW'($urandom_range(0, STG_DEPTH - 1));
            tbl_wr_data = CNT_W'($urandom_range(0, 15));
            cycle();
        end
        tbl_wr_en = 1'b0;
        enable    = 1'b0;
        cycle();

        phase = "async_reset";
        burst_mode  = 1'b0;
        stagger_len = 3'd1;
        wr(0, 10);
        pulse_width = 5;
        enable = 1'b1;
        repeat (12) cycle();
        rst_n = 1'b0;
        #1;
        check("async_rst_now", {2'b00, tx_pulse, pulse_start, busy, burst_done, pri_index}, 8'h00);
        model_reset();
        cycle();
        rst_n = 1'b1;
        phase = "default_pri";
        pulse_width = 3;
        repeat (2010) cycle();
        enable = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
